// File: rtl/sonido_pkg.sv
// rtl/sonido_pkg.sv - shared types and constants for the chirp generator
// Contents:
//   estado_t       : chirp FSM states (REPOSO, NOTA1, NOTA2)
//   CLK_HZ         : game clock frequency the default note constants derive from
//   *_DEF          : default half-periods and note length for CLK_HZ
//   f_ancho        : counter width for a modulus, never below 1 bit
package sonido_pkg;

  localparam int CLK_HZ        = 100_000_000;
  localparam int FREQ_NOTA1_HZ = 880;
  localparam int FREQ_NOTA2_HZ = 440;
  localparam int DUR_NOTA_MS   = 50;

  localparam int DIV_NOTA1_DEF = CLK_HZ / (2 * FREQ_NOTA1_HZ);
  localparam int DIV_NOTA2_DEF = CLK_HZ / (2 * FREQ_NOTA2_HZ);
  localparam int DUR_NOTA_DEF  = (CLK_HZ / 1000) * DUR_NOTA_MS;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    NOTA1  = 2'd1,
    NOTA2  = 2'd2
  } estado_t;

  // A modulus of 1 would give a zero-width counter; clamp to one bit.
  function automatic int f_ancho(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/generador_sonido_if.sv
// rtl/generador_sonido_if.sv - strobe/mute inputs and buzzer outputs of the chirp generator
// Signals:
//   pulso_sonido : award strobe from the score register
//   silencio     : mute, aborts playback and blocks triggers
//   altavoz      : square wave to the buzzer
//   sonando      : high while a chirp plays
// Modports:
//   master : score-register side (drives strobe and mute)
//   slave  : chirp generator side (drives buzzer and status)
interface generador_sonido_if;

  logic pulso_sonido;
  logic silencio;
  logic altavoz;
  logic sonando;

  modport master (
    output pulso_sonido,
    output silencio,
    input  altavoz,
    input  sonando
  );

  modport slave (
    input  pulso_sonido,
    input  silencio,
    output altavoz,
    output sonando
  );

endinterface

// File: rtl/divisor_tono.sv
// rtl/divisor_tono.sv - half-period counter producing a registered square wave
// Ports:
//   clk        : game clock
//   reset      : synchronous active-high reset
//   i_clear    : forces counter and wave to 0 (note entry / idle)
//   i_enable   : advance the counter this cycle
//   i_fin_semi : half-period minus one, terminal count of the counter
//   o_onda     : registered square wave
module divisor_tono #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_enable,
  input  logic [W-1:0] i_fin_semi,
  output logic         o_onda
);

  logic [W-1:0] r_cnt_t;
  logic         r_onda;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt_t <= '0;
      r_onda  <= 1'b0;
    end else if (i_enable) begin
      if (r_cnt_t == i_fin_semi) begin
        r_cnt_t <= '0;
        r_onda  <= ~r_onda;
      end else begin
        r_cnt_t <= r_cnt_t + 1'b1;
      end
    end
  end

  assign o_onda = r_onda;

endmodule

// File: rtl/generador_sonido.sv
// rtl/generador_sonido.sv - two-note chirp generator driving the board buzzer
// Build option: GENERADOR_SONIDO_DOS_NOTAS_EN
//   defined   : high note (DIV_NOTA1) followed by low note (DIV_NOTA2)
//   undefined : single note; DIV_NOTA2 only sizes the tone counter
// Parameters:
//   DIV_NOTA1 : half-period of note 1 in clk cycles (>=1)
//   DIV_NOTA2 : half-period of note 2 in clk cycles (>=1)
//   DUR_NOTA  : length of each note in clk cycles (>=2)
// Ports:
//   clk   : game clock
//   reset : synchronous active-high reset
//   bus   : slave side of generador_sonido_if (pulso_sonido, silencio in;
//           altavoz, sonando out, both registered)
module generador_sonido
  import sonido_pkg::*;
#(
  parameter int DIV_NOTA1 = DIV_NOTA1_DEF,
  parameter int DIV_NOTA2 = DIV_NOTA2_DEF,
  parameter int DUR_NOTA  = DUR_NOTA_DEF
) (
  input  logic               clk,
  input  logic               reset,
  generador_sonido_if.slave  bus
);

  localparam int W_T = f_ancho((DIV_NOTA1 > DIV_NOTA2) ? DIV_NOTA1 : DIV_NOTA2);
  localparam int W_D = f_ancho(DUR_NOTA);

  localparam logic [W_T-1:0] FIN_T1 = W_T'(DIV_NOTA1 - 1);
`ifdef GENERADOR_SONIDO_DOS_NOTAS_EN
  localparam logic [W_T-1:0] FIN_T2 = W_T'(DIV_NOTA2 - 1);
`endif
  localparam logic [W_D-1:0] FIN_D  = W_D'(DUR_NOTA - 1);

  estado_t        r_estado;
  estado_t        w_estado_sig;
  logic           r_prev;
  logic           r_sonando;
  logic [W_D-1:0] r_cnt_d;

  logic           w_disparo;
  logic           w_fin_nota;
  logic           w_entrada;
  logic           w_clear;
  logic           w_enable;
  logic [W_T-1:0] w_fin_semi;
  logic           w_altavoz;

  assign w_disparo  = bus.pulso_sonido & ~r_prev & ~bus.silencio;
  assign w_fin_nota = (r_cnt_d == FIN_D);

  always_comb begin
    w_estado_sig = r_estado;
    w_entrada    = 1'b0;
    if (bus.silencio) begin
      w_estado_sig = REPOSO;
    end else if (w_disparo) begin
      // Retrigger restarts the chirp from any state.
      w_estado_sig = NOTA1;
      w_entrada    = 1'b1;
    end else begin
      unique case (r_estado)
        REPOSO: w_estado_sig = REPOSO;
        NOTA1: begin
          if (w_fin_nota) begin
`ifdef GENERADOR_SONIDO_DOS_NOTAS_EN
            w_estado_sig = NOTA2;
            w_entrada    = 1'b1;
`else
            w_estado_sig = REPOSO;
`endif
          end
        end
`ifdef GENERADOR_SONIDO_DOS_NOTAS_EN
        NOTA2: begin
          if (w_fin_nota) w_estado_sig = REPOSO;
        end
`endif
        default: w_estado_sig = REPOSO;
      endcase
    end
    // Counters and wave restart on note entry and sit at 0 while idle, so
    // the buzzer drops low on the same edge the chirp ends or is muted.
    w_clear  = w_entrada | (w_estado_sig == REPOSO);
    w_enable = ~w_clear;
  end

`ifdef GENERADOR_SONIDO_DOS_NOTAS_EN
  assign w_fin_semi = (r_estado == NOTA2) ? FIN_T2 : FIN_T1;
`else
  assign w_fin_semi = FIN_T1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado  <= REPOSO;
      r_prev    <= 1'b0;
      r_sonando <= 1'b0;
      r_cnt_d   <= '0;
    end else begin
      r_estado  <= w_estado_sig;
      r_prev    <= bus.pulso_sonido;
      r_sonando <= (w_estado_sig != REPOSO);
      r_cnt_d   <= w_clear ? '0 : r_cnt_d + 1'b1;
    end
  end

  divisor_tono #(
    .W (W_T)
  ) u_divisor_tono (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_clear),
    .i_enable   (w_enable),
    .i_fin_semi (w_fin_semi),
    .o_onda     (w_altavoz)
  );

  assign bus.altavoz = w_altavoz;
  assign bus.sonando = r_sonando;

endmodule

// File: tb/tb_generador_sonido.sv
// tb/tb_generador_sonido.sv - scoreboard bench for generador_sonido
module tb_generador_sonido;

  localparam int DIV1 = 4;
  localparam int DIV2 = 2;
  localparam int DUR  = 16;
`ifdef GENERADOR_SONIDO_DOS_NOTAS_EN
  localparam int NOTAS = 2;
`else
  localparam int NOTAS = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  generador_sonido_if bus_if ();

  generador_sonido #(
    .DIV_NOTA1 (DIV1),
    .DIV_NOTA2 (DIV2),
    .DUR_NOTA  (DUR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct {
    int    ciclo;
    logic  altavoz;
    logic  sonando;
    string fase;
  } esperado_t;

  esperado_t sb[$];
  int        n_cmp = 0;
  int        n_err = 0;
  int        ciclo = 0;
  string     fase  = "init";

  // Reference model: time elapsed since the last trigger decides everything.
  bit m_prev   = 1'b0;
  bit m_activo = 1'b0;
  int m_e      = 0;

  task automatic paso(input logic p, input logic s, input logic r);
    logic      disparo;
    esperado_t x;
    reset               = r;
    bus_if.pulso_sonido = p;
    bus_if.silencio     = s;
    if (r) begin
      m_prev   = 1'b0;
      m_activo = 1'b0;
    end else begin
      disparo = p && !m_prev && !s;
      m_prev  = p;
      if (s) begin
        m_activo = 1'b0;
      end else if (disparo) begin
        m_activo = 1'b1;
        m_e      = 0;
      end else if (m_activo) begin
        m_e++;
        if (m_e >= NOTAS * DUR) m_activo = 1'b0;
      end
    end
    x.ciclo   = ciclo;
    x.fase    = fase;
    x.sonando = m_activo;
    if (!m_activo)      x.altavoz = 1'b0;
    else if (m_e < DUR) x.altavoz = ((m_e / DIV1) % 2) == 1;
    else                x.altavoz = (((m_e - DUR) / DIV2) % 2) == 1;
    @(posedge clk);
    sb.push_back(x);
    ciclo++;
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      esperado_t x;
      x = sb.pop_front();
      n_cmp++;
      if (bus_if.altavoz !== x.altavoz) begin
        n_err++;
        $display("FAIL altavoz[%s] cycle=%0d actual=%b required=%b",
                 x.fase, x.ciclo, bus_if.altavoz, x.altavoz);
      end
      n_cmp++;
      if (bus_if.sonando !== x.sonando) begin
        n_err++;
        $display("FAIL sonando[%s] cycle=%0d actual=%b required=%b",
                 x.fase, x.ciclo, bus_if.sonando, x.sonando);
      end
    end
  end

  initial begin
    logic sil;
    reset               = 1'b1;
    bus_if.pulso_sonido = 1'b0;
    bus_if.silencio     = 1'b0;

    fase = "reset";
    repeat (3) paso(0, 0, 1);
    fase = "idle";
    repeat (3) paso(0, 0, 0);

    fase = "single_pulse";
    paso(1, 0, 0);
    repeat (40) paso(0, 0, 0);

    fase = "held_pulse";
    repeat (5) paso(1, 0, 0);
    repeat (40) paso(0, 0, 0);

    fase = "retrigger";
    paso(1, 0, 0);
    repeat (25) paso(0, 0, 0);
    paso(1, 0, 0);
    repeat (40) paso(0, 0, 0);

    fase = "mute";
    paso(1, 0, 0);
    repeat (5) paso(0, 0, 0);
    for (int i = 0; i < 8; i++) paso(logic'(i % 2), 1, 0);
    repeat (10) paso(0, 0, 0);

    fase = "reset_mid_note";
    paso(1, 0, 0);
    repeat (7) paso(0, 0, 0);
    repeat (3) paso(1, 0, 1);
    paso(1, 0, 0);
    repeat (40) paso(0, 0, 0);

    fase = "random";
    sil = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) sil = ~sil;
      paso(logic'($urandom_range(0, 11) == 0), sil,
           logic'($urandom_range(0, 249) == 0));
    end
    fase = "tail";
    repeat (40) paso(0, 0, 0);

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
